// File: rtl/sprite_pkg.sv
// Shared types and select codes for the sprite scheduler and the sprite/palette mux.
package sprite_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] idx;
    logic       en;
  } obj_t;

  localparam logic [4:0] SEL_SHIP     = 5'd0;
  localparam logic [4:0] SEL_SHIP_2   = 5'd1;
  localparam logic [4:0] SEL_SHOT     = 5'd2;
  localparam logic [4:0] SEL_ENEMY1_1 = 5'd3;
  localparam logic [4:0] SEL_ENEMY1_2 = 5'd4;
  localparam logic [4:0] SEL_ENEMY2_1 = 5'd5;
  localparam logic [4:0] SEL_ENEMY2_2 = 5'd6;
  localparam logic [4:0] BKG_STAR     = 5'b11111;
  localparam logic [4:0] BKG_START    = 5'b01111;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } scan_state_t;

  // Widened to 11 bits so base + size cannot wrap near the top of the 10-bit range.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] base,
                                   input logic [10:0] size);
    return ({1'b0, base} <= {1'b0, pos}) && ({1'b0, pos} < ({1'b0, base} + size));
  endfunction

endpackage

// File: rtl/sprite_scheduler_line_resolver.sv
// Combinational per-pixel ownership: slot hit compare plus lowest-slot-wins priority encode.
module line_resolver
  import sprite_pkg::*;
#(
  parameter int LINE_SLOTS = 4,
  parameter int SPR_W      = 32
) (
  input  obj_t [LINE_SLOTS-1:0] slots,
  input  logic [9:0]            line_y,
  input  logic [9:0]            draw_x,
  input  logic                  vde,
  input  logic                  bkg_mode,
  output logic                  hit,
  output logic [4:0]            sel,
  output logic [4:0]            spr_row,
  output logic [4:0]            spr_col
);

  // Walk from the lowest-priority slot upward so slot 0 overrides everything.
  always_comb begin
    hit     = 1'b0;
    sel     = bkg_mode ? BKG_START : BKG_STAR;
    spr_row = '0;
    spr_col = '0;
    if (vde) begin
      for (int i = LINE_SLOTS - 1; i >= 0; i--) begin
        if (slots[i].en && in_span(draw_x, slots[i].x, 11'(SPR_W))) begin
          hit     = 1'b1;
          sel     = slots[i].idx;
          spr_row = 5'(line_y - slots[i].y);
          spr_col = 5'(draw_x - slots[i].x);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: object table, hblank scan into a line list, registered pixel resolve.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int N_OBJ      = 16,
  parameter int LINE_SLOTS = 4,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  input  logic                     obj_we,
  input  logic [$clog2(N_OBJ)-1:0] obj_addr,
  input  logic [9:0]               obj_x,
  input  logic [9:0]               obj_y,
  input  logic [4:0]               obj_idx,
  input  logic                     obj_en,
  input  logic                     bkg_mode,
  input  logic                     line_start,
  input  logic [9:0]               next_y,
  input  logic                     vde,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  output logic [4:0]               sel,
  output logic [4:0]               spr_row,
  output logic [4:0]               spr_col,
  output logic                     hit,
  output logic                     busy,
  output logic                     line_ovf
);

  localparam int AW = $clog2(N_OBJ);
  localparam int CW = $clog2(LINE_SLOTS + 1);
  localparam int SW = $clog2(LINE_SLOTS);

  obj_t                  table_q [N_OBJ];
  obj_t [LINE_SLOTS-1:0] shadow;
  obj_t [LINE_SLOTS-1:0] active;
  logic [CW-1:0]         shadow_cnt;
  logic                  shadow_ovf;
  logic [AW-1:0]         ptr;
  logic [9:0]            scan_y;
  logic [9:0]            active_y;
  scan_state_t           state;

  obj_t                  cur;
  logic                  qualifies;
  logic                  res_hit;
  logic [4:0]            res_sel;
  logic [4:0]            res_row;
  logic [4:0]            res_col;

  // The active list is always built for the line being drawn, so draw_y carries no information here.
  logic unused_draw_y;
  assign unused_draw_y = ^draw_y;

  assign cur       = table_q[ptr];
  assign qualifies = cur.en && in_span(scan_y, cur.y, 11'(SPR_H));

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_OBJ; i++) table_q[i] <= '0;
    end else if (obj_we) begin
      table_q[obj_addr] <= '{x: obj_x, y: obj_y, idx: obj_idx, en: obj_en};
    end
  end

  // line_start restarts from any state; the active list only changes in COMMIT.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      line_ovf   <= 1'b0;
      scan_y     <= '0;
      active_y   <= '0;
      ptr        <= '0;
      shadow     <= '0;
      shadow_cnt <= '0;
      shadow_ovf <= 1'b0;
      active     <= '0;
    end else if (line_start) begin
      state      <= SCAN;
      busy       <= 1'b1;
      scan_y     <= next_y;
      ptr        <= '0;
      shadow     <= '0;
      shadow_cnt <= '0;
      shadow_ovf <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (qualifies) begin
            if (shadow_cnt < CW'(LINE_SLOTS)) begin
              shadow[shadow_cnt[SW-1:0]] <= cur;
              shadow_cnt                 <= shadow_cnt + CW'(1);
            end else begin
              shadow_ovf <= 1'b1;
            end
          end
          if (ptr == AW'(N_OBJ - 1)) begin
            state <= COMMIT;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        COMMIT: begin
          active   <= shadow;
          active_y <= scan_y;
          line_ovf <= shadow_ovf;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  line_resolver #(
    .LINE_SLOTS(LINE_SLOTS),
    .SPR_W     (SPR_W)
  ) u_resolver (
    .slots   (active),
    .line_y  (active_y),
    .draw_x  (draw_x),
    .vde     (vde),
    .bkg_mode(bkg_mode),
    .hit     (res_hit),
    .sel     (res_sel),
    .spr_row (res_row),
    .spr_col (res_col)
  );

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      sel     <= BKG_STAR;
      hit     <= 1'b0;
      spr_row <= '0;
      spr_col <= '0;
    end else begin
      sel     <= res_sel;
      hit     <= res_hit;
      spr_row <= res_row;
      spr_col <= res_col;
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scenario bench for sprite_scheduler: expected pixels are queued at drive time and popped on output.
module tb_sprite_scheduler;
  import sprite_pkg::*;

  localparam int N_OBJ = 16;
  localparam logic [15:0] BG0 = {BKG_STAR, 10'd0, 1'b0};
  localparam logic [15:0] BG1 = {BKG_START, 10'd0, 1'b0};

  typedef struct {
    int          x;
    logic        v;
    logic        b;
    logic [15:0] e;
  } pix_t;

  logic       pixel_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       obj_we = 1'b0;
  logic [3:0] obj_addr = '0;
  logic [9:0] obj_x = '0;
  logic [9:0] obj_y = '0;
  logic [4:0] obj_idx = '0;
  logic       obj_en = 1'b0;
  logic       bkg_mode = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_y = '0;
  logic       vde = 1'b0;
  logic [9:0] draw_x = '0;
  logic [9:0] draw_y = '0;
  logic [4:0] sel, spr_row, spr_col;
  logic       hit, busy, line_ovf;

  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];

  always #5 pixel_clk = ~pixel_clk;

  sprite_scheduler dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .obj_we    (obj_we),
    .obj_addr  (obj_addr),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .obj_idx   (obj_idx),
    .obj_en    (obj_en),
    .bkg_mode  (bkg_mode),
    .line_start(line_start),
    .next_y    (next_y),
    .vde       (vde),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .sel       (sel),
    .spr_row   (spr_row),
    .spr_col   (spr_col),
    .hit       (hit),
    .busy      (busy),
    .line_ovf  (line_ovf)
  );

  function automatic logic [15:0] pk(input int s, input int r, input int c, input int h);
    return {5'(s), 5'(r), 5'(c), 1'(h)};
  endfunction

  task automatic write_obj(input int a, input int x, input int y, input int idx, input int en);
    obj_we = 1'b1; obj_addr = 4'(a); obj_x = 10'(x); obj_y = 10'(y);
    obj_idx = 5'(idx); obj_en = 1'(en);
    @(negedge pixel_clk);
    obj_we = 1'b0;
  endtask

  task automatic pix(input int x, input logic v, input logic b, input logic [15:0] e);
    draw_x = 10'(x); vde = v; bkg_mode = b;
    sb.push_back(e);
    @(negedge pixel_clk);
  endtask

  // Pulses line_start and counts cycles until busy drops, bounded at 100.
  task automatic run_scan(input int y, output int n);
    line_start = 1'b1; next_y = 10'(y);
    @(negedge pixel_clk);
    line_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge pixel_clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [17:0] got;
    logic [15:0] g, e;
    pix_t t[3];
    reset_n = 1'b0;
    repeat (2) @(negedge pixel_clk);
    got = {sel, spr_row, spr_col, hit, busy, line_ovf};
    total++;
    if (got !== {BKG_STAR, 10'd0, 3'b000}) begin
      bad++; $display("[TB] FAIL reset_values got=%h want=%h", got, {BKG_STAR, 10'd0, 3'b000});
    end
    reset_n = 1'b1;
    @(negedge pixel_clk);
    t = '{'{100, 1'b1, 1'b0, BG0}, '{100, 1'b1, 1'b1, BG1}, '{100, 1'b0, 1'b1, BG1}};
    foreach (t[i]) begin
      pix(t[i].x, t[i].v, t[i].b, t[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL reset_pix[%0d] got=%h want=%h", i, g, e); end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    int n;
    logic [15:0] g, e;
    pix_t t[6];
    write_obj(2, 100, 50, 7, 1);
    run_scan(60, n);
    total++;
    if (n !== N_OBJ + 1) begin bad++; $display("[TB] FAIL single_busy got=%0d want=%0d", n, N_OBJ + 1); end
    t = '{'{105, 1'b1, 1'b0, pk(7, 10, 5, 1)}, '{131, 1'b1, 1'b0, pk(7, 10, 31, 1)},
          '{132, 1'b1, 1'b0, BG0}, '{99, 1'b1, 1'b0, BG0},
          '{105, 1'b0, 1'b1, BG1}, '{105, 1'b1, 1'b1, pk(7, 10, 5, 1)}};
    foreach (t[i]) begin
      pix(t[i].x, t[i].v, t[i].b, t[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL single_pix[%0d] got=%h want=%h", i, g, e); end
    end
    run_scan(81, n);
    pix(100, 1'b1, 1'b0, pk(7, 31, 0, 1));
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL single_last_row got=%h want=%h", g, e); end
    run_scan(82, n);
    pix(100, 1'b1, 1'b0, BG0);
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL single_below got=%h want=%h", g, e); end
  endtask

  task automatic test_priority();
    int n;
    logic [15:0] g, e;
    pix_t t[5];
    write_obj(2, 100, 50, 7, 0);
    write_obj(3, 200, 300, 9, 1);
    write_obj(5, 190, 300, 10, 1);
    run_scan(300, n);
    t = '{'{210, 1'b1, 1'b0, pk(9, 0, 10, 1)}, '{195, 1'b1, 1'b0, pk(10, 0, 5, 1)},
          '{225, 1'b1, 1'b0, pk(9, 0, 25, 1)}, '{189, 1'b1, 1'b0, BG0},
          '{232, 1'b1, 1'b0, BG0}};
    foreach (t[i]) begin
      pix(t[i].x, t[i].v, t[i].b, t[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL priority_pix[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [15:0] g, e;
    pix_t t[6];
    pix_t u[2];
    write_obj(3, 200, 300, 9, 0);
    write_obj(5, 190, 300, 10, 0);
    write_obj(1, 50, 39, 2, 1);
    write_obj(4, 200, 36, 5, 1);
    write_obj(6, 300, 34, 7, 1);
    write_obj(8, 400, 32, 9, 1);
    write_obj(10, 500, 30, 11, 1);
    write_obj(12, 600, 28, 13, 1);
    run_scan(40, n);
    total++;
    if (line_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b want=1", line_ovf); end
    t = '{'{53, 1'b1, 1'b0, pk(2, 1, 3, 1)}, '{203, 1'b1, 1'b0, pk(5, 4, 3, 1)},
          '{303, 1'b1, 1'b0, pk(7, 6, 3, 1)}, '{403, 1'b1, 1'b0, pk(9, 8, 3, 1)},
          '{503, 1'b1, 1'b0, BG0}, '{603, 1'b1, 1'b0, BG0}};
    foreach (t[i]) begin
      pix(t[i].x, t[i].v, t[i].b, t[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL ovf_pix[%0d] got=%h want=%h", i, g, e); end
    end
    run_scan(63, n);
    total++;
    if (line_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_exact4 got=%b want=0", line_ovf); end
    u = '{'{403, 1'b1, 1'b0, pk(9, 31, 3, 1)}, '{503, 1'b1, 1'b0, BG0}};
    foreach (u[i]) begin
      pix(u[i].x, u[i].v, u[i].b, u[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL exact4_pix[%0d] got=%h want=%h", i, g, e); end
    end
    run_scan(70, n);
    total++;
    if (line_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_single got=%b want=0", line_ovf); end
    u = '{'{53, 1'b1, 1'b0, pk(2, 31, 3, 1)}, '{203, 1'b1, 1'b0, BG0}};
    foreach (u[i]) begin
      pix(u[i].x, u[i].v, u[i].b, u[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL single_line_pix[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_restart();
    int n;
    logic [15:0] g, e;
    pix_t t[3];
    foreach (t[i]) t[i] = '{0, 1'b0, 1'b0, 16'h0};
    write_obj(1, 50, 39, 2, 0);
    write_obj(4, 200, 36, 5, 0);
    write_obj(6, 300, 34, 7, 0);
    write_obj(8, 400, 32, 9, 0);
    write_obj(10, 500, 30, 11, 0);
    write_obj(12, 600, 28, 13, 0);
    write_obj(0, 10, 100, 3, 1);
    write_obj(7, 10, 200, 4, 1);
    line_start = 1'b1; next_y = 10'd100;
    @(negedge pixel_clk);
    line_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy_rise got=%b want=1", busy); end
    t[0] = '{53, 1'b1, 1'b0, pk(2, 31, 3, 1)};
    pix(t[0].x, t[0].v, t[0].b, t[0].e);
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL restart_old_list got=%h want=%h", g, e); end
    repeat (3) @(negedge pixel_clk);
    run_scan(200, n);
    total++;
    if (n !== N_OBJ + 1) begin bad++; $display("[TB] FAIL restart_busy got=%0d want=%0d", n, N_OBJ + 1); end
    t[1] = '{15, 1'b1, 1'b0, pk(4, 0, 5, 1)};
    t[2] = '{12, 1'b1, 1'b0, pk(4, 0, 2, 1)};
    for (int i = 1; i < 3; i++) begin
      pix(t[i].x, t[i].v, t[i].b, t[i].e);
      g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
      if (g !== e) begin bad++; $display("[TB] FAIL restart_pix[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    logic [15:0] g, e;
    logic [17:0] got;
    line_start = 1'b1; next_y = 10'd200;
    @(negedge pixel_clk);
    line_start = 1'b0;
    pix(15, 1'b1, 1'b0, pk(4, 0, 5, 1));
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL midscan_hold got=%h want=%h", g, e); end
    @(negedge pixel_clk);
    #2 reset_n = 1'b0;
    #1;
    got = {sel, spr_row, spr_col, hit, busy, line_ovf};
    total++;
    if (got !== {BKG_STAR, 10'd0, 3'b000}) begin
      bad++; $display("[TB] FAIL midscan_reset got=%h want=%h", got, {BKG_STAR, 10'd0, 3'b000});
    end
    @(negedge pixel_clk);
    reset_n = 1'b1;
    pix(15, 1'b1, 1'b0, BG0);
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL reset_active_clear got=%h want=%h", g, e); end
    run_scan(200, n);
    total++;
    if (n !== N_OBJ + 1) begin bad++; $display("[TB] FAIL post_reset_busy got=%0d want=%0d", n, N_OBJ + 1); end
    pix(15, 1'b1, 1'b0, BG0);
    g = {sel, spr_row, spr_col, hit}; e = sb.pop_front(); total++;
    if (g !== e) begin bad++; $display("[TB] FAIL reset_table_clear got=%h want=%h", g, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_restart();
    test_reset_mid_scan();
    total++;
    if (sb.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-scanline sprite scheduler that drives the select input of the sprite/palette mux and the row/column address of the selected sprite ROM. It holds a small object table written by the game logic, scans it during horizontal blanking to build a list of objects that cover the next scanline, then resolves per pixel which object, or which background, owns the current pixel. It sits between the VGA/HDMI timing generator and the sprite ROM bank and select mux, in the pixel clock domain.

## Interface
- N_OBJ, 16: object table depth (power of two)
- LINE_SLOTS, 4: maximum objects displayable on one scanline
- SPR_W, 32: sprite width in pixels
- SPR_H, 32: sprite height in pixels
- BKG_STAR, 5'b11111: select code for star background
- BKG_START, 5'b01111: select code for start-screen background
- pixel_clk  in  1  pixel clock; everything is synchronous to its rising edge
- reset_n  in  1  asynchronous, active-low reset
- obj_we  in  1  object table write strobe
- obj_addr  in  $clog2(N_OBJ)  object entry to write
- obj_x, obj_y  in  10 each  top-left corner of the object
- obj_idx  in  5  sprite/palette select code for the object
- obj_en  in  1  object visible
- bkg_mode  in  1  0 selects BKG_STAR, 1 selects BKG_START
- line_start  in  1  single-cycle pulse at the start of hblank
- next_y  in  10  scanline to prepare; sampled with line_start
- vde  in  1  active video
- draw_x, draw_y  in  10 each  current pixel
- sel  out  5  mux select code
- spr_row, spr_col  out  5 each  offset inside the sprite (draw − obj), 0 on background
- hit  out  1  a sprite owns the pixel
- busy  out  1  scan in progress
- line_ovf  out  1  more than LINE_SLOTS objects covered the last scanned line

## Operation
- Object table: N_OBJ registers {x, y, idx, en}. A write takes effect on the edge where obj_we is high and is visible to a scan one cycle later.
- FSM states are IDLE, SCAN, and COMMIT.
  - IDLE → SCAN on line_start. Latch next_y, clear the shadow list and the shadow overflow flag, and set the entry pointer to 0.
  - SCAN: examine one entry per cycle. An entry qualifies when en = 1 and obj_y ≤ next_y < obj_y + SPR_H. The sum is computed in 11 bits, so no wrap.
    - A qualifying entry goes into the next free shadow slot.
    - If all slots are full, the entry is dropped and the shadow overflow flag is set.
    - After entry N_OBJ−1, go to COMMIT.
  - COMMIT: copy the shadow list to the active list and the shadow overflow flag to line_ovf, then go to IDLE. This state lasts one cycle.
  - line_start during SCAN or COMMIT restarts the scan with the new next_y. The active list is left untouched.
- Priority: a lower object index wins. Slot order preserves index order, and slot 0 is highest priority.
- Pixel resolve, using the active list:
  - A slot hits when obj_x ≤ draw_x < obj_x + SPR_W (11-bit compare).
  - The lowest hitting slot drives sel = idx, spr_row = next_y_latched − obj_y, spr_col = draw_x − obj_x, and hit = 1. Both offsets are truncated to 5 bits.
  - With no hit, sel = bkg_mode ? BKG_START : BKG_STAR, hit = 0, and both offsets are 0.
  - With vde = 0, output the background select with hit = 0.
- draw_y is not compared. The active list was built for the line being displayed.

## Timing
- Reset values:
  - sel = BKG_STAR, hit = 0, spr_row = spr_col = 0, busy = 0, line_ovf = 0
  - FSM in IDLE, all table en = 0, active and shadow lists empty
- Scan latency: line_start at cycle t; busy is high for t+1 … t+N_OBJ+1 (SCAN plus COMMIT); the new list is active from cycle t+N_OBJ+2. This fits well inside a 160-cycle hblank.
- Pixel latency: inputs at cycle t, registered outputs valid at t+1.
- reset_n asserted mid-scan aborts immediately and restores all reset values.

## Structure
- Package sprite_pkg holds:
  - the obj_t struct {x, y, idx, en}
  - the select-code localparams (ship … enemy2_2, BKG_STAR, BKG_START), shared with the mux
  - the FSM state enum
- Sub-module line_resolver holds the combinational slot hit compare and priority encode. The result is registered in sprite_scheduler.

## Test plan
- Reset, then vde = 1 at draw_x = 100 with bkg_mode = 0 → sel = 5'b11111, hit = 0, busy = 0.
- Object 2 = {x 100, y 50, idx 7, en 1}, line_start with next_y = 60, wait 18 cycles, then draw_x = 105 → sel = 7, spr_row = 10, spr_col = 5, hit = 1. At draw_x = 132 → background.
- Objects 3 and 5 overlap at x = 200 (idx 9 and 10) → sel = 9 at draw_x = 210.
- Six enabled objects all covering next_y = 40 → the four lowest indices are listed and line_ovf = 1. The next line with one object → line_ovf = 0.
- line_start pulsed again 5 cycles into a scan → busy stays high for N_OBJ+1 cycles from the second pulse, and the list reflects the second next_y.
- reset_n low during SCAN → outputs at reset values, the table is cleared, and the previous object no longer hits after a fresh scan.
